// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU behind valid/ready request and response ports.
// Single-cycle ops (add, sub, and, or, xor, lui, sll, srl, sra, slt, sltu)
// register their result on acceptance. mulu (shift-add) and divu (restoring
// shift-subtract) iterate one bit per cycle for WIDTH cycles.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake; inputA, inputB, ALUOp, shamt
//   out_valid/out_ready response handshake; response held until accepted
//   ALUOut, ALUOutHi    result low word / high word (product hi, remainder)
//   zero                ALUOut == 0
//   overflow            signed overflow for add/sub
//   div_zero            divu issued with inputB == 0
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [3:0]       ALUOp,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] lo_q, lo_d;       // result low / multiplier / dividend-quotient
  logic [WIDTH-1:0] hi_q, hi_d;       // result high / partial product / remainder
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             is_multi;
  logic [WIDTH-1:0] sc_sum, sc_dif, sc_res;
  logic             sc_ovf;
  logic [WIDTH:0]   padd, shifted;
  logic [WIDTH-1:0] dtry, hi_n, lo_n;
  logic             ge;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;
  assign is_multi  = (ALUOp == 4'd11) | (ALUOp == 4'd12);

  assign ALUOut   = lo_q;
  assign ALUOutHi = hi_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;

  // Single-cycle result straight from the request inputs.
  always_comb begin
    sc_sum = inputA + inputB;
    sc_dif = inputA - inputB;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUOp)
      4'd0: begin
        sc_res = sc_sum;
        sc_ovf = (inputA[WIDTH-1] == inputB[WIDTH-1]) && (sc_sum[WIDTH-1] != inputA[WIDTH-1]);
      end
      4'd1: begin
        sc_res = sc_dif;
        sc_ovf = (inputA[WIDTH-1] != inputB[WIDTH-1]) && (sc_dif[WIDTH-1] != inputA[WIDTH-1]);
      end
      4'd2:    sc_res = inputA & inputB;
      4'd3:    sc_res = inputA | inputB;
      4'd4:    sc_res = inputA ^ inputB;
      4'd5:    sc_res = inputB << (WIDTH / 2);
      4'd6:    sc_res = inputB << shamt;
      4'd7:    sc_res = inputB >> shamt;
      4'd8:    sc_res = $signed(inputB) >>> shamt;
      4'd9:    sc_res = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
      4'd10:   sc_res = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
      default: sc_res = '0;
    endcase
  end

  // One iteration step of mul or div.
  always_comb begin
    padd    = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd_q};
    // Only used when ge, where the true difference fits in WIDTH bits.
    dtry    = shifted[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      hi_n = ge ? dtry : shifted[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_n = padd[WIDTH:1];
      lo_n = {padd[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;

    case (state_q)
      StBusy: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          zero_d  = (lo_n == '0);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: ;
    endcase

    // A new request overrides whatever the current state decided.
    if (accept) begin
      if (is_multi) begin
        state_d  = StBusy;
        cnt_d    = CW'(WIDTH);
        is_div_d = (ALUOp == 4'd12);
        opnd_d   = (ALUOp == 4'd12) ? inputB : inputA;
        lo_d     = (ALUOp == 4'd12) ? inputA : inputB;
        hi_d     = '0;
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        dz_d     = (ALUOp == 4'd12) && (inputB == '0);
      end else begin
        state_d = StDone;
        lo_d    = sc_res;
        hi_d    = '0;
        zero_d  = (sc_res == '0);
        ovf_d   = sc_ovf;
        dz_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed requests; a reference model predicts each
// response and the cycle it must appear; one negedge process checks
// handshake signals every cycle and response contents whenever valid.
module tb_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  inputA = '0;
  logic [W-1:0]  inputB = '0;
  logic [3:0]    ALUOp = '0;
  logic [4:0]    shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  ALUOut, ALUOutHi;
  logic          zero, overflow, div_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    logic         dz;
    int           due;
  } exp_t;

  exp_t q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inputA    (inputA),
    .inputB    (inputB),
    .ALUOp     (ALUOp),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOut    (ALUOut),
    .ALUOutHi  (ALUOutHi),
    .zero      (zero),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference behaviour from the operation definitions, using wide integers.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, output logic [W-1:0] lo,
                                output logic [W-1:0] hi, output logic ovf, output logic dz);
    longint s;
    logic [2*W-1:0] p;
    lo = '0; hi = '0; ovf = 1'b0; dz = 1'b0;
    case (op)
      4'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        lo = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        lo = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  lo = a & b;
      4'd3:  lo = a | b;
      4'd4:  lo = a ^ b;
      4'd5:  lo = b * 32'd65536;
      4'd6:  lo = b << sh;
      4'd7:  lo = b >> sh;
      4'd8:  lo = $signed(b) >>> sh;
      4'd9:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: lo = (a < b) ? 32'd1 : 32'd0;
      4'd11: begin
        p = {32'd0, a} * {32'd0, b};
        lo = p[W-1:0];
        hi = p[2*W-1:W];
      end
      4'd12: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op);
    return (op == 4'd11 || op == 4'd12) ? W + 1 : 1;
  endfunction

  // Pin the model against hand-computed results.
  task automatic pin(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] elo,
                     input logic [W-1:0] ehi, input logic eovf, input logic edz);
    logic [W-1:0] lo, hi;
    logic ovf, dz;
    model(op, a, b, sh, lo, hi, ovf, dz);
    vectors++;
    if (lo !== elo || hi !== ehi || ovf !== eovf || dz !== edz) begin
      miscompares++;
      $display("FAIL model_%s: got lo=%h hi=%h ovf=%b dz=%b want lo=%h hi=%h ovf=%b dz=%b",
               name, lo, hi, ovf, dz, elo, ehi, eovf, edz);
    end
  endtask

  // Checker: handshake every cycle, contents whenever a response is due.
  always @(negedge clk) begin
    logic exp_v, exp_r;
    logic [W-1:0] lo, hi;
    logic ovf, dz;
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUOut !== '0 || ALUOutHi !== '0 ||
          zero !== 1'b0 || overflow !== 1'b0 || div_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: ov=%b ir=%b lo=%h hi=%h z=%b o=%b dz=%b want all 0, ir=1",
                 out_valid, in_ready, ALUOut, ALUOutHi, zero, overflow, div_zero);
      end
    end else begin
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      exp_r = (q.size() == 0) || (exp_v && out_ready);
      vectors++;
      if (out_valid !== exp_v || in_ready !== exp_r) begin
        miscompares++;
        $display("FAIL handshake cyc %0d: out_valid=%b in_ready=%b want %b %b",
                 cyc, out_valid, in_ready, exp_v, exp_r);
      end
      if (exp_v && out_valid === 1'b1) begin
        vectors++;
        if (ALUOut !== q[0].lo || ALUOutHi !== q[0].hi || zero !== (q[0].lo == 0) ||
            overflow !== q[0].ovf || div_zero !== q[0].dz) begin
          miscompares++;
          $display("FAIL result cyc %0d: lo=%h hi=%h z=%b o=%b dz=%b want lo=%h hi=%h z=%b o=%b dz=%b",
                   cyc, ALUOut, ALUOutHi, zero, overflow, div_zero,
                   q[0].lo, q[0].hi, (q[0].lo == 0), q[0].ovf, q[0].dz);
        end
      end
      if (exp_v && out_ready) void'(q.pop_front());
      if (in_valid && exp_r) begin
        model(ALUOp, inputA, inputB, shamt, lo, hi, ovf, dz);
        e.lo = lo; e.hi = hi; e.ovf = ovf; e.dz = dz;
        e.due = cyc + latency(ALUOp);
        q.push_back(e);
      end
    end
  end

  // Present a request and hold it until the next edge accepts it.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    int n;
    in_valid = 1'b1; ALUOp = op; inputA = a; inputB = b; shamt = sh;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: op %0d in_ready=%b want 1 within 100 cycles", op, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d responses pending want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pin("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 32'd0, 1'b1, 1'b0);
    pin("sub_zero", 4'd1, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    pin("sra", 4'd8, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 32'd0, 1'b0, 1'b0);
    pin("lui", 4'd5, 32'd0, 32'h1234, 5'd0, 32'h12340000, 32'd0, 1'b0, 1'b0);
    pin("slt", 4'd9, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    pin("sltu", 4'd10, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    pin("mulu", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0);
    pin("divu", 4'd12, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 1'b0);
    pin("divu0", 4'd12, 32'd9, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b1);
    pin("sub_ovf", 4'd1, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 32'd0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a multiply: the response must never appear.
    issue(4'd11, 32'd5, 32'd6, 5'd0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(4'd0, 32'd3, 32'd4, 5'd0);
    drain();

    issue(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0);
    issue(4'd1, 32'd5, 32'd5, 5'd0);
    issue(4'd8, 32'd0, 32'h80000000, 5'd4);
    issue(4'd5, 32'd0, 32'h1234, 5'd0);
    issue(4'd9, 32'hFFFFFFFF, 32'd1, 5'd0);
    issue(4'd10, 32'hFFFFFFFF, 32'd1, 5'd0);
    issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    issue(4'd12, 32'd100, 32'd7, 5'd0);
    issue(4'd12, 32'd9, 32'd0, 5'd0);
    issue(4'd11, 32'h12345678, 32'h9ABCDEF0, 5'd0);
    issue(4'd12, 32'hDEADBEEF, 32'h00001234, 5'd0);
    issue(4'd6, 32'd0, 32'h0000F00F, 5'd28);
    issue(4'd7, 32'd0, 32'h80000001, 5'd31);
    issue(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
    issue(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
    issue(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    for (int i = 0; i < 4; i++) issue(4'd4, 32'hA5A5A5A5 + i, 32'h0F0F0F0F, 5'd0);
    drain();

    // Back-pressure: response held, in_ready low, second request waits.
    out_ready = 1'b0;
    issue(4'd4, 32'h12345678, 32'hFFFF0000, 5'd0);
    in_valid = 1'b1; ALUOp = 4'd0; inputA = 32'd1; inputB = 32'd2;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    issue(4'd0, 32'd1, 32'd2, 5'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
